// File: rtl/dsp_dly_pkg.sv
// ---------------------------------------------------------------------------
// dsp_dly_pkg
// Shared definitions for the runtime-programmable register delay line.
//   - default sizing constants for the delay line
//   - ch_lsb(): bit offset of channel k inside a packed multi-channel word
//   - wrap_sub(): modular read-index subtraction (one conditional add)
//   - lw_fits(): sizing rule for the length / pointer width
// ---------------------------------------------------------------------------
package dsp_dly_pkg;

  localparam int DW_DEF      = 36;
  localparam int NCH_DEF     = 2;
  localparam int MAX_LEN_DEF = 12;
  localparam int LW_DEF      = 4;

  // Channel k occupies bits [ch_lsb(k, dw) +: dw] of a packed sample word.
  function automatic int ch_lsb(input int k, input int dw);
    return k * dw;
  endfunction

  // (a - b) wrapped into 0..m-1, valid for 0 <= a < m and 0 <= b <= m.
  // A single conditional add of m replaces a modulo operator.
  function automatic int wrap_sub(input int a, input int b, input int m);
    int d;
    d = a - b;
    if (d < 0) d = d + m;
    return d;
  endfunction

  // The len port, write pointer and fill counter share a width that must
  // be able to represent max_len itself.
  function automatic bit lw_fits(input int lw, input int max_len);
    return (2 ** lw) > max_len;
  endfunction

endpackage

// File: rtl/var_reg_delay_if.sv
// ---------------------------------------------------------------------------
// var_reg_delay_if
// Sample / control bundle of the delay line.
//   gate       : sample strobe (buffer advances only when high)
//   len        : requested delay in gate strobes
//   din        : nch packed samples, channel k at [k*dw +: dw]
//   dout       : delayed samples, same packing
//   dout_valid : dout holds real data for the current effective length
//   len_err    : len exceeds max_len
// Modports: master drives gate/len/din, slave (the delay line) drives the
// outputs.
// ---------------------------------------------------------------------------
interface var_reg_delay_if
  import dsp_dly_pkg::*;
#(
  parameter int dw  = DW_DEF,
  parameter int nch = NCH_DEF,
  parameter int lw  = LW_DEF
);
  logic                gate;
  logic [lw-1:0]       len;
  logic [nch*dw-1:0]   din;
  logic [nch*dw-1:0]   dout;
  logic                dout_valid;
  logic                len_err;

  modport master (
    output gate, len, din,
    input  dout, dout_valid, len_err
  );

  modport slave (
    input  gate, len, din,
    output dout, dout_valid, len_err
  );
endinterface

// File: rtl/dly_ring_mem.sv
// ---------------------------------------------------------------------------
// dly_ring_mem
// Circular register buffer: depth entries of width bits, async-reset to 0,
// with an explicitly wrapping write pointer and a combinational read port.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   we_i         : write strobe; writes wdata_i at the write pointer and
//                  advances the pointer
//   wdata_i      : write data
//   rd_idx_i     : read index (0..depth-1)
//   wp_o         : current write pointer
//   rdata_o      : entry at rd_idx_i
// ---------------------------------------------------------------------------
module dly_ring_mem
  import dsp_dly_pkg::*;
#(
  parameter int width = NCH_DEF * DW_DEF,
  parameter int depth = MAX_LEN_DEF,
  parameter int pw    = LW_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_i,
  input  logic [width-1:0] wdata_i,
  input  logic [pw-1:0]    rd_idx_i,
  output logic [pw-1:0]    wp_o,
  output logic [width-1:0] rdata_o
);

  localparam logic [pw-1:0] LAST = pw'(depth - 1);

  logic [width-1:0] mem_q [depth];
  logic [pw-1:0]    wp_q;
  logic [pw-1:0]    wp_d;

  // Explicit wrap: depth need not be a power of two.
  assign wp_d = (wp_q == LAST) ? '0 : wp_q + pw'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q <= '0;
      for (int i = 0; i < depth; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      wp_q        <= wp_d;
      mem_q[wp_q] <= wdata_i;
    end
  end

  assign wp_o    = wp_q;
  assign rdata_o = mem_q[rd_idx_i];

endmodule

// File: rtl/var_reg_delay.sv
// ---------------------------------------------------------------------------
// var_reg_delay
// Multi-channel gated delay line with runtime length 0..max_len.
// Ports:
//   clk     : sole clock, rising edge
//   reset_n : asynchronous active-low reset (release synchronised outside)
//   bus     : var_reg_delay_if.slave (gate, len, din -> dout, dout_valid,
//             len_err)
// Optional build macro VAR_REG_DELAY_OUT_REG_EN: dout/dout_valid go through
// one ungated output register (adds 1 clk of latency, including the len=0
// passthrough). len_err is always combinational.
// ---------------------------------------------------------------------------
module var_reg_delay
  import dsp_dly_pkg::*;
#(
  parameter int dw      = DW_DEF,
  parameter int nch     = NCH_DEF,
  parameter int max_len = MAX_LEN_DEF,
  parameter int lw      = LW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  var_reg_delay_if.slave bus
);

  localparam int            W         = nch * dw;
  localparam logic [lw-1:0] MAX_LEN_L = lw'(max_len);

  generate
    if (!lw_fits(lw, max_len)) begin : g_lw_chk
      $fatal(1, "var_reg_delay: lw too small, 2**lw must exceed max_len");
    end
    if (max_len < 1) begin : g_len_chk
      $fatal(1, "var_reg_delay: max_len must be at least 1");
    end
  endgenerate

  logic [lw-1:0] wp;
  logic [lw-1:0] rd_idx;
  logic [lw-1:0] eff_len;
  logic [lw-1:0] fill_q;
  logic [lw-1:0] fill_d;
  logic [W-1:0]  rdata;
  logic [W-1:0]  dout_d;
  logic          valid_d;
  logic          len_err;

  assign len_err = (bus.len > MAX_LEN_L);
  assign eff_len = len_err ? MAX_LEN_L : bus.len;
  assign rd_idx  = lw'(wrap_sub(int'(wp), int'(eff_len), max_len));

  dly_ring_mem #(
    .width (W),
    .depth (max_len),
    .pw    (lw)
  ) u_mem (
    .clk      (clk),
    .reset_n  (reset_n),
    .we_i     (bus.gate),
    .wdata_i  (bus.din),
    .rd_idx_i (rd_idx),
    .wp_o     (wp),
    .rdata_o  (rdata)
  );

  // Fill count saturates at max_len; it is what makes dout_valid honest
  // after reset and after the length is increased.
  assign fill_d = (bus.gate && (fill_q != MAX_LEN_L)) ? fill_q + lw'(1) : fill_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fill_q <= '0;
    else          fill_q <= fill_d;
  end

  assign valid_d = (fill_q >= eff_len);

  // Zero length bypasses the buffer entirely, per channel.
  generate
    for (genvar gi = 0; gi < nch; gi++) begin : g_ch
      assign dout_d[ch_lsb(gi, dw) +: dw] = (eff_len == '0) ? bus.din[ch_lsb(gi, dw) +: dw]
                                                            : rdata[ch_lsb(gi, dw) +: dw];
    end
  endgenerate

`ifdef VAR_REG_DELAY_OUT_REG_EN
  logic [W-1:0] dout_q;
  logic         valid_q;

  // Clocked every cycle, not gated, so a length change still shows up
  // one clk later even without a strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = valid_q;
`else
  // The buffer is already cleared while in reset, but the len=0 passthrough
  // is not, so the outputs are forced explicitly.
  assign bus.dout       = reset_n ? dout_d : '0;
  assign bus.dout_valid = reset_n & valid_d;
`endif

  assign bus.len_err = len_err;

endmodule

// File: tb/tb_var_reg_delay.sv
// ---------------------------------------------------------------------------
// tb_var_reg_delay
// Self-checking bench for var_reg_delay (dw=36, nch=2, max_len=12, lw=4).
// Every gated sample is pushed onto a history queue (newest first); the
// expected output for length L is the entry L-1 deep, or zero/invalid when
// fewer than L samples exist since reset.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_var_reg_delay;
  localparam int DW      = 36;
  localparam int NCH     = 2;
  localparam int MAX_LEN = 12;
  localparam int LW      = 4;
  localparam int W       = NCH * DW;

  logic clk;
  logic reset_n;

  var_reg_delay_if #(.dw(DW), .nch(NCH), .lw(LW)) bus ();

  var_reg_delay #(
    .dw      (DW),
    .nch     (NCH),
    .max_len (MAX_LEN),
    .lw      (LW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_errors = 0;
  int             n        = 0;
  logic [W-1:0]   hist[$];
  logic [W-1:0]   exp_prev_dout  = '0;
  logic           exp_prev_valid = 1'b0;

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ramp(input int k);
    logic [DW-1:0] c0;
    logic [DW-1:0] c1;
    c0 = DW'(k);
    c1 = DW'(k + 32'h100);
    return {c1, c0};
  endfunction

  // One clock: drive at negedge, check, then model the write at posedge.
  task automatic cycle(input logic g, input logic [LW-1:0] l);
    int           eff;
    logic [W-1:0] exp_dout;
    logic         exp_valid;
    bus.gate = g;
    bus.len  = l;
    bus.din  = ramp(n);
    #1;
    eff = (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
    if (eff == 0) begin
      exp_dout  = bus.din;
      exp_valid = 1'b1;
    end else if (hist.size() >= eff) begin
      exp_dout  = hist[eff-1];
      exp_valid = 1'b1;
    end else begin
      exp_dout  = '0;
      exp_valid = 1'b0;
    end
`ifdef VAR_REG_DELAY_OUT_REG_EN
    check_eq("dout", bus.dout, exp_prev_dout);
    check_eq("dout_valid", W'(bus.dout_valid), W'(exp_prev_valid));
`else
    check_eq("dout", bus.dout, exp_dout);
    check_eq("dout_valid", W'(bus.dout_valid), W'(exp_valid));
`endif
    check_eq("len_err", W'(bus.len_err), W'(int'(l) > MAX_LEN));
    $display("t=%0t g=%0b len=%0d din0=%0h dout0=%0h dout1=%0h v=%0b err=%0b",
             $time, g, l, bus.din[DW-1:0], bus.dout[DW-1:0], bus.dout[W-1:DW],
             bus.dout_valid, bus.len_err);
    @(posedge clk);
    exp_prev_dout  = exp_dout;
    exp_prev_valid = exp_valid;
    if (g) begin
      hist.push_front(bus.din);
      if (hist.size() > MAX_LEN) void'(hist.pop_back());
      n++;
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted between edges, held over two rising edges.
  task automatic mid_reset();
    #2;
    reset_n  = 1'b0;
    bus.gate = 1'b0;
    #1;
    check_eq("rst_async_dout", bus.dout, '0);
    check_eq("rst_async_valid", W'(bus.dout_valid), '0);
    check_eq("rst_async_len_err", W'(bus.len_err), W'(int'(bus.len) > MAX_LEN));
    $display("t=%0t async reset asserted dout0=%0h v=%0b", $time, bus.dout[DW-1:0], bus.dout_valid);
    hist.delete();
    exp_prev_dout  = '0;
    exp_prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    bus.gate = 1'b0;
    bus.len  = LW'(6);
    bus.din  = '0;
    reset_n  = 1'b0;
    @(negedge clk);
    #1;
    check_eq("rst_dout", bus.dout, '0);
    check_eq("rst_valid", W'(bus.dout_valid), '0);
    check_eq("rst_len_err6", W'(bus.len_err), '0);
    bus.len = LW'(15);
    #1;
    check_eq("rst_len_err15", W'(bus.len_err), W'(1));
    bus.len = LW'(0);
    bus.din = ramp(77);
    #1;
    check_eq("rst_len0_dout", bus.dout, '0);
    check_eq("rst_len0_valid", W'(bus.dout_valid), '0);
    bus.len = LW'(6);
    bus.din = '0;
    reset_n = 1'b1;
    @(negedge clk);

    // Continuous gating at len=6.
    for (int i = 0; i < 20; i++) cycle(1'b1, LW'(6));
    // Gate every third cycle: output must hold between strobes.
    for (int i = 0; i < 18; i++) cycle(i % 3 == 0, LW'(6));
    // Shorten to 2: valid immediately from kept history.
    for (int i = 0; i < 5; i++) cycle(1'b1, LW'(2));

    // Lengthen to 11 with only 6 samples since reset.
    mid_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, LW'(6));
    for (int i = 0; i < 10; i++) cycle(1'b1, LW'(11));

    // Zero-length passthrough, gated and ungated.
    for (int i = 0; i < 6; i++) cycle(i % 2 == 0, LW'(0));
    // Out-of-range length clamps to 12 across several pointer wraps.
    for (int i = 0; i < 30; i++) cycle(1'b1, LW'(15));
    for (int i = 0; i < 3; i++) cycle(1'b1, LW'(12));

    // Reset mid-stream at len=4: valid returns after exactly 4 gates.
    for (int i = 0; i < 8; i++) cycle(1'b1, LW'(4));
    mid_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, LW'(4));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/var_reg_delay.md
Name: var_reg_delay

Overview:
- Runtime-programmable, multi-channel register delay line: next generation of the fixed-length gated delay used in the DSP chain.
- Delays `nch` parallel channels of `dw`-bit samples by `len` gate strobes.
- `len` is selectable at runtime from 0 to `max_len`, with no resynthesis.
- Implemented as a circular register buffer, with a fill-tracking valid flag and out-of-range length detection.
- Sits between ADC/CIC stages and phase/amplitude processing to align channel paths with differing latency.

Parameters:
- `dw`, 36: sample width per channel, bits.
- `nch`, 2: number of channels; all channels share the gate and the delay setting.
- `max_len`, 12: maximum delay in gate strobes. Must be ≥1; need not be a power of 2.
- `lw`, 4: width of the `len` port. Must satisfy 2^lw > `max_len`.

Ports:
- `clk`, input, 1: sole clock; everything on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `gate`, input, 1: sample strobe. The buffer advances only when high.
- `len`, input, `lw`: requested delay in gate strobes, quasi-static.
- `din`, input, `nch`*`dw`: channel k occupies bits [k*dw +: dw].
- `dout`, output, `nch`*`dw`: delayed samples, same packing as `din`.
- `dout_valid`, output, 1: `dout` holds real (non-reset) data for the current effective length.
- `len_err`, output, 1: high while `len` > `max_len`.

Behaviour:
Storage and pointers:
- Storage is `mem[0..max_len-1]`, each entry `nch`*`dw` bits wide.
- Write pointer `wp` ranges 0..`max_len`-1.
- Fill counter `fill` ranges 0..`max_len` and saturates at `max_len`.

Reset:
- Async assertion clears `mem`, `wp` and `fill` to 0.
- While `reset_n` is low: `dout` = 0, `dout_valid` = 0, `len_err` reflects `len` combinationally.
- Release is synchronised by the environment; the block applies no internal synchroniser.

Gate (on a clk edge with `gate` = 1):
- `mem[wp]` <= `din`.
- `wp` <= (`wp` == `max_len`-1) ? 0 : `wp`+1 (explicit wrap, not modulo 2^n).
- `fill` <= min(`fill`+1, `max_len`).
- `gate` = 0: no state changes.

Effective length and read path:
- `eff_len` = (`len` > `max_len`) ? `max_len` : `len`.
- `len_err` = (`len` > `max_len`), combinational.
- Read index `rd` = (`wp` - `eff_len`) wrapped into 0..`max_len`-1, computed with one conditional add of `max_len`, no divider.
- `eff_len` = 0: `dout` = `din` (combinational passthrough) and `dout_valid` = 1.
- `eff_len` ≥ 1: `dout` = `mem[rd]`, the sample written exactly `eff_len` gate strobes earlier.
- `dout_valid` = (`fill` ≥ `eff_len`), combinational.

Latency:
- `dout` changes on the clk edge following a gated write.
- Equivalent to an `eff_len`-stage gated shift register.

Length changes:
- No flush. The buffer keeps history, so shortening takes effect immediately with valid data.
- Lengthening beyond `fill` drops `dout_valid` until enough strobes accumulate.

Reset mid-operation:
- All history is lost; `fill` restarts at 0.

Simultaneous events:
- Reset dominates gate.
- A `len` change coincident with gate uses the new `len` for the read after the write.

Optional Feature:
- Macro `VAR_REG_DELAY_OUT_REG_EN`.
- Defined:
  - `dout` and `dout_valid` pass through one output register clocked every cycle, not gated.
  - Total latency is `eff_len` strobes plus 1 clk.
  - The `eff_len` = 0 path is registered too, giving 1 clk latency.
  - Both registers reset to 0.
- Undefined: combinational read as specified above. `len_err` is never registered.

Decomposition:
- Package `dsp_dly_pkg` holds:
  - the channel-slice helper constants;
  - function `wrap_sub(a, b, m)` for the modular read index;
  - the `lw` sizing rule as an elaboration-time check (fatal if 2^lw ≤ `max_len`).
- One natural sub-module, `dly_ring_mem`: the `max_len`-entry async-reset register array with the write pointer and a combinational read port.
- Fill, valid, clamp and output-register logic stays in `var_reg_delay`.

Test Plan:
- `dw`=36, `nch`=2, `max_len`=12, `len`=6, `gate`=1, `din` = ramp (ch0 = n, ch1 = n+0x100). Expect:
  - `dout_valid` rises on the 6th gated edge;
  - then `dout` ch0 = n-6 and ch1 = n-6+0x100 every cycle.
- `len`=6, `gate` high every 3rd cycle, ramp advancing only on gate. Expect:
  - `dout` = ramp-6 counted in strobes;
  - `dout` constant between strobes.
- Steady state at `len`=6, then switch `len` to 2. Expect:
  - next cycle `dout` = n-2 and `dout_valid` stays 1.
- Switch `len` to 11 with only 6 samples since reset. Expect:
  - `dout_valid` = 0 until `fill` = 11, then `dout` = n-11.
- `len`=0: `dout` == `din` same cycle and `dout_valid` = 1. `len`=15: `len_err` = 1, and `dout` behaves as `len`=12, including correct wrap after `wp` passes 11.
- Pull `reset_n` low mid-stream for 2 cycles with `len`=4. Expect:
  - `dout` = 0 and `dout_valid` = 0 immediately (async);
  - after release, `dout_valid` returns after exactly 4 gates.
